id_stage_queue: RTL and testbench

// - Parametrised, elastic successor to the fixed ID-stage handoff registers.

---
 rtl/id_stage_queue.sv | 107 ++++++++++
 tb/tb_id_stage_queue.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/id_stage_queue.sv
// Elastic DEPTH-entry queue between two decode/rename stages carrying pc, payload and prediction fields.
// Optional zero-latency bypass of an empty queue: define ID_QUEUE_BYPASS_EN.
module id_stage_queue #(
   parameter int unsigned WIDTH     = 32,
   parameter int unsigned ADR_WIDTH = 32,
   parameter int unsigned PAYLOAD_W = 64,
   parameter int unsigned DEPTH     = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     flush,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [WIDTH-1:0]         in_pc,
   input  logic [PAYLOAD_W-1:0]     in_payload,
   input  logic [ADR_WIDTH-1:0]     in_pred_adr,
   input  logic                     in_branch_jump,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [WIDTH-1:0]         out_pc,
   output logic [PAYLOAD_W-1:0]     out_payload,
   output logic [ADR_WIDTH-1:0]     out_pred_adr,
   output logic                     out_branch_jump,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned PW = AW + 1;

   typedef struct packed {
      logic [WIDTH-1:0]     pc;
      logic [PAYLOAD_W-1:0] payload;
      logic [ADR_WIDTH-1:0] pred_adr;
      logic                 branch_jump;
   } entry_t;

   generate
      if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
         $error("id_stage_queue: DEPTH must be a power of two and >= 2");
      end
   endgenerate

   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   entry_t        mem [DEPTH];
   entry_t        in_entry;
   entry_t        head;
   logic          empty;
   logic          full;
   logic          bypass;
   logic          push;
   logic          pop;

   assign in_entry = '{pc: in_pc, payload: in_payload, pred_adr: in_pred_adr,
                       branch_jump: in_branch_jump};

   // Wrap bit distinguishes full from empty when the low bits match.
   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);

`ifdef ID_QUEUE_BYPASS_EN
   assign bypass = empty && in_valid && out_ready && !flush && !rst;
`else
   assign bypass = 1'b0;
`endif

   // Handshake, head selection and occupancy; a bypassed entry never touches storage.
   always_comb begin
      in_ready  = !full && !rst;
      push      = in_valid && in_ready && !flush && !bypass;
      pop       = !empty && !rst && out_ready && !flush;
      out_valid = 1'b0;
      head      = '0;
      if (bypass) begin
         out_valid = 1'b1;
         head      = in_entry;
      end else if (!empty && !rst) begin
         out_valid = 1'b1;
         head      = mem[rd_ptr[AW-1:0]];
      end
      count = rst ? '0 : PW'(wr_ptr - rd_ptr);
   end

   assign out_pc          = head.pc;
   assign out_payload     = head.payload;
   assign out_pred_adr    = head.pred_adr;
   assign out_branch_jump = head.branch_jump;

   // Pointer update: reset over flush over push/pop.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else if (flush) begin
         rd_ptr <= wr_ptr;
      end else begin
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop)  rd_ptr <= rd_ptr + PW'(1);
      end
   end

   // Entry storage is deliberately left uncleared by reset.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr[AW-1:0]] <= in_entry;
   end

endmodule

// File: tb/tb_id_stage_queue.sv
// Self-checking bench for id_stage_queue: directed scenarios then random traffic against a queue model.
// Honours ID_QUEUE_BYPASS_EN when defined for the build.
module tb_id_stage_queue;

   localparam int unsigned DEPTH = 4;
   localparam int unsigned CW    = 3;

   typedef struct packed {
      logic [31:0] pc;
      logic [63:0] payload;
      logic [31:0] pred;
      logic        bj;
   } ent_t;

   logic          clk = 1'b0;
   logic          rst;
   logic          flush;
   logic          in_valid;
   logic          in_ready;
   logic          out_valid;
   logic          out_ready;
   logic [31:0]   out_pc;
   logic [63:0]   out_payload;
   logic [31:0]   out_pred_adr;
   logic          out_branch_jump;
   logic [CW-1:0] count;
   ent_t          cur;

   ent_t model_q[$];
   int   checks = 0;
   int   errors = 0;
   logic accepted = 1'b0;

   always #5 clk = ~clk;

   id_stage_queue #(.WIDTH(32), .ADR_WIDTH(32), .PAYLOAD_W(64), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_pc(cur.pc), .in_payload(cur.payload), .in_pred_adr(cur.pred),
      .in_branch_jump(cur.bj),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_pc(out_pc), .out_payload(out_payload), .out_pred_adr(out_pred_adr),
      .out_branch_jump(out_branch_jump), .count(count)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // One clock: check outputs mid-cycle against the model, then advance the model at the edge.
   task automatic cycle();
      ent_t          head;
      logic          bypass, e_valid, e_ready, push, pop;
      logic [CW-1:0] e_count;
      @(negedge clk);
`ifdef ID_QUEUE_BYPASS_EN
      bypass = (model_q.size() == 0) && in_valid && out_ready && !flush && !rst;
`else
      bypass = 1'b0;
`endif
      e_ready = !rst && (model_q.size() < DEPTH);
      e_valid = !rst && ((model_q.size() > 0) || bypass);
      head    = '0;
      if (bypass)       head = cur;
      else if (e_valid) head = model_q[0];
      e_count = rst ? '0 : CW'(model_q.size());
      chk("in_ready",        64'(in_ready),        64'(e_ready));
      chk("out_valid",       64'(out_valid),       64'(e_valid));
      chk("count",           64'(count),           64'(e_count));
      chk("out_pc",          64'(out_pc),          64'(head.pc));
      chk("out_payload",     out_payload,          head.payload);
      chk("out_pred_adr",    64'(out_pred_adr),    64'(head.pred));
      chk("out_branch_jump", 64'(out_branch_jump), 64'(head.bj));
      push     = in_valid && e_ready && !flush && !bypass;
      pop      = e_valid && out_ready && !flush && !bypass;
      accepted = in_valid && e_ready && !flush;
      @(posedge clk);
      if (rst || flush) begin
         model_q.delete();
      end else begin
         if (pop)  void'(model_q.pop_front());
         if (push) model_q.push_back(cur);
      end
      #1;
   endtask

   function automatic ent_t mk(input logic [31:0] pc);
      ent_t e;
      e.pc      = pc;
      e.payload = {$urandom, $urandom};
      e.pred    = $urandom;
      e.bj      = 1'($urandom);
      return e;
   endfunction

   initial begin
      int          stream_cnt;
      logic [31:0] seq;
`ifdef ID_QUEUE_BYPASS_EN
      stream_cnt = 0;
`else
      stream_cnt = 1;
`endif
      // Reset with a producer already asserting valid
      rst = 1'b1; flush = 1'b0; out_ready = 1'b0; in_valid = 1'b1; cur = mk(32'h50);
      cycle();
      cycle();
      rst = 1'b0; in_valid = 1'b0;
      cycle();
      chk("ready_after_rst", 64'(in_ready), 64'(1));
      chk("count_after_rst", 64'(count), 64'(0));

      // Fill to DEPTH with the consumer stalled; 5th entry must be held
      for (int i = 0; i < 4; i++) begin
         cur = mk(32'h100 + 32'(4 * i)); in_valid = 1'b1;
         cycle();
      end
      cur = mk(32'h110);
      cycle();
      cycle();
      chk("fill_count", 64'(count), 64'(4));
      chk("fill_ready", 64'(in_ready), 64'(0));
      chk("fill_head",  64'(out_pc), 64'(32'h100));
      out_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         cycle();
         if (accepted) in_valid = 1'b0;
      end
      chk("drained", 64'(out_valid), 64'(0));

      // Streaming, pc step 4, wraps the pointers
      for (int i = 0; i < 10; i++) begin
         cur = mk(32'h200 + 32'(4 * i)); in_valid = 1'b1;
         cycle();
         chk("stream_count", 64'(count), 64'(stream_cnt));
      end
      in_valid = 1'b0;
      cycle();

      // Flush with a push and a pop pending in the same cycle
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         cur = mk(32'h300 + 32'(4 * i)); in_valid = 1'b1;
         cycle();
      end
      cur = mk(32'h30C); out_ready = 1'b1; flush = 1'b1;
      cycle();
      flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      chk("flush_count", 64'(count), 64'(0));
      chk("flush_valid", 64'(out_valid), 64'(0));
      chk("flush_ready", 64'(in_ready), 64'(1));
      cycle();

      // Prediction fields behind a stall
      cur = '{pc: 32'h400, payload: 64'h0123_4567_89AB_CDEF, pred: 32'hDEAD_BEE0, bj: 1'b1};
      in_valid = 1'b1;
      cycle();
      in_valid = 1'b0; cur = mk(32'h404);
      cycle();
      chk("br_pc",   64'(out_pc), 64'(32'h400));
      chk("br_pred", 64'(out_pred_adr), 64'(32'hDEAD_BEE0));
      chk("br_bj",   64'(out_branch_jump), 64'(1));
      out_ready = 1'b1;
      cycle();
      out_ready = 1'b0;

      // Random traffic; producer holds an unaccepted entry
      seq = 32'h1000;
      for (int i = 0; i < 10000; i++) begin
         if (!(in_valid && !accepted)) begin
            in_valid = ($urandom_range(9) < 7);
            if (in_valid) begin
               cur = mk(seq);
               seq += 32'd4;
            end
         end
         out_ready = ($urandom_range(9) < 6);
         flush     = ($urandom_range(49) == 0);
         rst       = ($urandom_range(999) == 0);
         cycle();
      end
      rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      cycle();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
